// File: rtl/bp_me_pkg.sv
// rtl/bp_me_pkg.sv - shared constants and assembly state type for the byte packer
package bp_me_pkg;

   localparam int byte_width_gp = 8;

   typedef enum logic {
      e_pack_fill = 1'b0,
      e_pack_full = 1'b1
   } bp_pack_state_e;

endpackage

// File: rtl/bsg_one_fifo.sv
// rtl/bsg_one_fifo.sv - one-entry holding register with valid bit and same-cycle refill on dequeue
module bsg_one_fifo #(
   parameter int width_p = 32
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   output logic               ready_o,
   input  logic [width_p-1:0] data_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   logic               full_q, full_d;
   logic [width_p-1:0] data_q, data_d;

   // Ready includes the dequeue so a new word can replace the departing one on the same edge.
   assign ready_o = ~full_q | yumi_i;
   assign v_o     = full_q;
   assign data_o  = data_q;

   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (v_i & ready_o) begin
         full_d = 1'b1;
         data_d = data_i;
      end else if (yumi_i) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/bp_stream_byte_packer.sv
// rtl/bp_stream_byte_packer.sv - packs a byte stream into little-endian words; BP_STREAM_BYTE_PACKER_CHECKSUM_EN adds a byte sum
module bp_stream_byte_packer
   import bp_me_pkg::*;
#(
   parameter int stream_data_width_p = 32
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic                           in_v_i,
   input  logic [7:0]                     in_data_i,
   output logic                           in_ready_o,
   input  logic                           flush_i,
   output logic                           out_v_o,
   output logic [stream_data_width_p-1:0] out_data_o,
   input  logic                           out_ready_i,
   output logic [31:0]                    word_count_o,
   output logic [31:0]                    checksum_o
);

   localparam int lanes_lp  = stream_data_width_p / byte_width_gp;
   localparam int lane_w_lp = $clog2(lanes_lp + 1);
   localparam logic [lane_w_lp-1:0] lanes_full_lp = lane_w_lp'(lanes_lp);

   logic [lane_w_lp-1:0]           lane_q, lane_d, lane_inc;
   logic [stream_data_width_p-1:0] asm_q, asm_d, asm_fill;
   logic [31:0]                    word_count_q, word_count_d;
   bp_pack_state_e                 asm_state;
   logic                           accept, complete, fifo_ready, out_v, yumi;

   assign asm_state  = (lane_q == lanes_full_lp) ? e_pack_full : e_pack_fill;
   assign in_ready_o = (asm_state == e_pack_fill) & ~reset_i;
   assign accept     = in_v_i & in_ready_o;
   assign yumi       = out_v & out_ready_i;
   assign out_v_o    = out_v;

   always_comb begin
      asm_fill = asm_q;
      for (int l = 0; l < lanes_lp; l++) begin
         if (accept && (lane_q == lane_w_lp'(l)))
            asm_fill[byte_width_gp*l +: byte_width_gp] = in_data_i;
      end
      lane_inc = lane_q + lane_w_lp'(accept);
      // A same-cycle byte lands before the flush; an empty or already-full word ignores flush.
      complete = (lane_inc == lanes_full_lp)
               | (flush_i & (asm_state == e_pack_fill) & (lane_inc != '0));
      lane_d = lane_inc;
      asm_d  = asm_fill;
      if (complete & fifo_ready) begin
         lane_d = '0;
         asm_d  = '0;
      end else if (complete) begin
         lane_d = lanes_full_lp;
      end
      word_count_d = word_count_q + 32'(yumi);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         lane_q       <= '0;
         asm_q        <= '0;
         word_count_q <= '0;
      end else begin
         lane_q       <= lane_d;
         asm_q        <= asm_d;
         word_count_q <= word_count_d;
      end
   end

   bsg_one_fifo #(
      .width_p(stream_data_width_p)
   ) hold (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .v_i    (complete),
      .ready_o(fifo_ready),
      .data_i (asm_fill),
      .v_o    (out_v),
      .data_o (out_data_o),
      .yumi_i (yumi)
   );

   assign word_count_o = word_count_q;

`ifdef BP_STREAM_BYTE_PACKER_CHECKSUM_EN
   logic [31:0] checksum_q;

   always_ff @(posedge clk_i) begin
      if (reset_i)
         checksum_q <= '0;
      else if (accept)
         checksum_q <= checksum_q + 32'(in_data_i);
   end

   assign checksum_o = checksum_q;
`else
   assign checksum_o = '0;
`endif

endmodule
